// File: rtl/parity_pkg.sv
// Shared parity types and helpers for the stream parity generator/checker.
// Mode encoding matches the in_odd/chk_odd port bit directly.
package parity_pkg;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_mode_e;

  localparam int PAR_MAX_W = 64;

  // Zero-extension is harmless: extra zeros never change the XOR reduction.
  function automatic logic parity_bit(
    input logic [PAR_MAX_W-1:0] data,
    input parity_mode_e         mode
  );
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational parity reduction with odd/even mode invert.
// Used for generating the parity bit and for flagging bad frames.
module parity_calc
  import parity_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] data,
  input  parity_mode_e mode,
  output logic         p
);

  generate
    if (W <= PAR_MAX_W) begin : g_fn
      logic [PAR_MAX_W-1:0] data_ext;
      assign data_ext = PAR_MAX_W'(data);
      assign p = parity_bit(data_ext, mode);
    end else begin : g_wide
      assign p = (^data) ^ (mode == PAR_ODD);
    end
  endgenerate

endmodule

// File: rtl/parity_stream_gen_chk.sv
// Pipelined parity generator (valid/ready) and receive-side checker.
// Optional saturating error counter: define PARITY_ERR_CNT_EN.
module parity_stream_gen_chk
  import parity_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_odd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_frame,
  input  logic             chk_valid,
  input  logic [WIDTH:0]   chk_frame,
  input  logic             chk_odd,
  output logic             chk_err,
  output logic             err_sticky,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int FRAME_W = WIDTH + 1;

  logic               gen_p;
  logic               accept;
  logic               drain;
  logic               valid_q;
  logic [FRAME_W-1:0] frame_q;

  parity_calc #(.W(WIDTH)) u_gen_calc (
    .data (in_data),
    .mode (parity_mode_e'(in_odd)),
    .p    (gen_p)
  );

  assign in_ready  = ~valid_q | out_ready;
  assign accept    = in_valid & in_ready;
  assign drain     = valid_q & out_ready;
  assign out_valid = valid_q;
  assign out_frame = frame_q;

  // Frame is left untouched on drain so the bus stays quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      frame_q <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      frame_q <= {in_data, gen_p};
    end else if (drain) begin
      valid_q <= 1'b0;
    end
  end

  // With mode folded in, a nonzero result means the frame is bad.
  logic chk_bad;
  logic err_hit;
  logic err_q;
  logic sticky_q;

  parity_calc #(.W(FRAME_W)) u_chk_calc (
    .data (chk_frame),
    .mode (parity_mode_e'(chk_odd)),
    .p    (chk_bad)
  );

  assign err_hit = chk_valid & chk_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      err_q    <= err_hit;
      sticky_q <= (sticky_q & ~err_clr) | err_hit;
    end
  end

  assign chk_err    = err_q;
  assign err_sticky = sticky_q;

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (err_clr) begin
      cnt_q <= CNT_W'(err_hit);
    end else if (err_hit && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_parity_stream_gen_chk.sv
// Self-checking bench for parity_stream_gen_chk (WIDTH=4, CNT_W=2).
// Generator output is scored against a popcount reference model.
module tb_parity_stream_gen_chk;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_odd;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_frame;
  logic             chk_valid;
  logic [WIDTH:0]   chk_frame;
  logic             chk_odd;
  logic             chk_err;
  logic             err_sticky;
  logic             err_clr;
  logic [CNT_W-1:0] err_cnt;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;
  logic [WIDTH:0] sb[$];

  parity_stream_gen_chk #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_odd     (in_odd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_frame  (out_frame),
    .chk_valid  (chk_valid),
    .chk_frame  (chk_frame),
    .chk_odd    (chk_odd),
    .chk_err    (chk_err),
    .err_sticky (err_sticky),
    .err_clr    (err_clr),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic int ones(input logic [WIDTH:0] v);
    int n = 0;
    for (int i = 0; i <= WIDTH; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [WIDTH:0] model_frame(
    input logic [WIDTH-1:0] d, input logic odd);
    logic p;
    p = logic'(ones({1'b0, d}) % 2) ^ odd;
    return {d, p};
  endfunction

  function automatic logic model_err(
    input logic [WIDTH:0] f, input logic odd);
    return odd ? (ones(f) % 2 == 0) : (ones(f) % 2 == 1);
  endfunction

  function automatic logic [CNT_W-1:0] model_cnt(input int n);
`ifdef PARITY_ERR_CNT_EN
    int mx = (1 << CNT_W) - 1;
    return CNT_W'((n > mx) ? mx : n);
`else
    return CNT_W'(0 * n);
`endif
  endfunction

  // Handshakes are decided at the coming posedge; inputs are stable here.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_underflow: got %b, no frame expected", out_frame);
        end else begin
          logic [WIDTH:0] e;
          e = sb.pop_front();
          if (out_frame !== e) begin
            failures++;
            $display("FAIL sb_frame: got %b expected %b", out_frame, e);
          end
        end
      end
      if (in_valid && in_ready)
        sb.push_back(model_frame(in_data, in_odd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = '0;
    in_odd    = 1'b0;
    out_ready = 1'b1;
    chk_valid = 1'b0;
    chk_frame = '0;
    chk_odd   = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    checks += 6;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_out_valid: got %b expected 0", out_valid);
    end
    if (out_frame !== '0) begin
      failures++; $display("FAIL rst_out_frame: got %b expected 0", out_frame);
    end
    if (chk_err !== 1'b0) begin
      failures++; $display("FAIL rst_chk_err: got %b expected 0", chk_err);
    end
    if (err_sticky !== 1'b0) begin
      failures++; $display("FAIL rst_sticky: got %b expected 0", err_sticky);
    end
    if (err_cnt !== '0) begin
      failures++; $display("FAIL rst_cnt: got %0d expected 0", err_cnt);
    end
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_in_ready: got %b expected 1", in_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_gen_basic();
    in_valid = 1'b1; in_data = 4'b0000; in_odd = 1'b1; out_ready = 1'b1;
    tick();
    checks += 2;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL gen0_valid: got %b expected 1", out_valid);
    end
    if (out_frame !== 5'b00001) begin
      failures++; $display("FAIL gen0_frame: got %b expected 00001", out_frame);
    end
    in_data = 4'b1011; in_odd = 1'b0;
    tick();
    checks++;
    if (out_frame !== 5'b10111) begin
      failures++; $display("FAIL gen1_frame: got %b expected 10111", out_frame);
    end
    in_valid = 1'b0;
    tick();
    checks += 2;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL gen_drain_valid: got %b expected 0", out_valid);
    end
    if (out_frame !== 5'b10111) begin
      failures++; $display("FAIL gen_drain_hold: got %b expected 10111", out_frame);
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH:0] held;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'b0110; in_odd = 1'b0;
    held = model_frame(4'b0110, 1'b0);
    tick();
    in_data = 4'b1110; in_odd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks += 3;
      if (in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready);
      end
      if (out_valid !== 1'b1) begin
        failures++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, out_valid);
      end
      if (out_frame !== held) begin
        failures++;
        $display("FAIL bp_frame[%0d]: got %b expected %b", i, out_frame, held);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = WIDTH'(i * 3 + 1);
      in_odd  = i[0];
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL bp_sb_empty: got %0d left expected 0", sb.size());
    end
  endtask

  task automatic test_checker();
    chk_valid = 1'b1; chk_frame = 5'b10110; chk_odd = 1'b1;
    tick();
    checks++;
    if (chk_err !== 1'b0) begin
      failures++; $display("FAIL chk_good_odd: got %b expected 0", chk_err);
    end
    chk_frame = 5'b10111;
    tick();
    checks += 2;
    if (chk_err !== 1'b1) begin
      failures++; $display("FAIL chk_bad_odd: got %b expected 1", chk_err);
    end
    if (err_sticky !== 1'b1) begin
      failures++; $display("FAIL chk_sticky_set: got %b expected 1", err_sticky);
    end
    chk_odd = 1'b0;
    tick();
    checks += 2;
    if (chk_err !== 1'b0) begin
      failures++; $display("FAIL chk_good_even: got %b expected 0", chk_err);
    end
    if (err_sticky !== 1'b1) begin
      failures++; $display("FAIL chk_sticky_hold: got %b expected 1", err_sticky);
    end
    chk_valid = 1'b0; chk_odd = 1'b1;
    tick();
    checks++;
    if (chk_err !== 1'b0) begin
      failures++; $display("FAIL chk_no_valid: got %b expected 0", chk_err);
    end
  endtask

  task automatic test_err_clr();
    err_clr = 1'b1; chk_valid = 1'b0;
    tick();
    checks += 2;
    if (err_sticky !== 1'b0) begin
      failures++; $display("FAIL clr_alone: got %b expected 0", err_sticky);
    end
    if (err_cnt !== '0) begin
      failures++; $display("FAIL clr_cnt0: got %0d expected 0", err_cnt);
    end
    chk_valid = 1'b1; chk_frame = 5'b00000; chk_odd = 1'b1;
    tick();
    checks += 3;
    if (err_sticky !== 1'b1) begin
      failures++; $display("FAIL clr_with_err: got %b expected 1", err_sticky);
    end
    if (chk_err !== 1'b1) begin
      failures++; $display("FAIL clr_chk_err: got %b expected 1", chk_err);
    end
    if (err_cnt !== model_cnt(1)) begin
      failures++;
      $display("FAIL clr_cnt1: got %0d expected %0d", err_cnt, model_cnt(1));
    end
    chk_valid = 1'b0;
    tick();
    checks++;
    if (err_sticky !== 1'b0) begin
      failures++; $display("FAIL clr_again: got %b expected 0", err_sticky);
    end
    err_clr = 1'b0;
  endtask

  task automatic test_err_cnt();
    chk_valid = 1'b1; chk_frame = 5'b11000; chk_odd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks += 2;
      if (chk_err !== 1'b1) begin
        failures++; $display("FAIL cnt_err[%0d]: got %b expected 1", i, chk_err);
      end
      if (err_cnt !== model_cnt(i + 1)) begin
        failures++;
        $display("FAIL cnt_val[%0d]: got %0d expected %0d",
                 i, err_cnt, model_cnt(i + 1));
      end
    end
    chk_valid = 1'b0;
    tick();
    checks++;
    if (err_cnt !== model_cnt(5)) begin
      failures++;
      $display("FAIL cnt_hold: got %0d expected %0d", err_cnt, model_cnt(5));
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_cnt !== '0) begin
      failures++; $display("FAIL cnt_clr: got %0d expected 0", err_cnt);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'b1001; in_odd = 1'b1;
    chk_valid = 1'b1; chk_frame = 5'b00011; chk_odd = 1'b1;
    tick();
    in_valid = 1'b0; chk_valid = 1'b0;
    checks += 2;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL ar_pre_valid: got %b expected 1", out_valid);
    end
    if (chk_err !== 1'b1) begin
      failures++; $display("FAIL ar_pre_err: got %b expected 1", chk_err);
    end
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL ar_valid: got %b expected 0", out_valid);
    end
    if (chk_err !== 1'b0) begin
      failures++; $display("FAIL ar_chk_err: got %b expected 0", chk_err);
    end
    if (err_sticky !== 1'b0) begin
      failures++; $display("FAIL ar_sticky: got %b expected 0", err_sticky);
    end
    if (err_cnt !== '0) begin
      failures++; $display("FAIL ar_cnt: got %0d expected 0", err_cnt);
    end
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    mon_en = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 4'b0110; in_odd = 1'b1;
    tick();
    in_valid = 1'b0;
    checks += 2;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL ar_fresh_valid: got %b expected 1", out_valid);
    end
    if (out_frame !== 5'b01101) begin
      failures++; $display("FAIL ar_fresh_frame: got %b expected 01101", out_frame);
    end
    tick();
  endtask

  task automatic test_random();
    int  n_acc = 0;
    int  cyc   = 0;
    logic exp_err = 1'b0;
    while (n_acc < 10000 && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      in_data   = WIDTH'($urandom);
      in_odd    = 1'($urandom);
      out_ready = 1'($urandom);
      chk_valid = 1'($urandom);
      chk_frame = (WIDTH + 1)'($urandom);
      chk_odd   = 1'($urandom);
      if (in_valid && (!out_valid || out_ready)) n_acc++;
      exp_err = chk_valid && model_err(chk_frame, chk_odd);
      tick();
      cyc++;
      checks++;
      if (chk_err !== exp_err) begin
        failures++;
        $display("FAIL rnd_chk_err[%0d]: got %b expected %b", cyc, chk_err, exp_err);
      end
    end
    checks++;
    if (n_acc < 10000) begin
      failures++; $display("FAIL rnd_budget: got %0d words expected 10000", n_acc);
    end
    in_valid = 1'b0; out_ready = 1'b1; chk_valid = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL rnd_drain: got %0d left expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_gen_basic();
    test_backpressure();
    test_checker();
    test_err_clr();
    test_err_cnt();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
